// File: rtl/tics_module.sv
// TICS flop: single-bit set/clear/load/toggle storage element with complementary registered outputs.
// Define TICS_SYNC_EN to insert a SYNC_STAGES-deep synchronizer on each control input.
module tics_module #(
    parameter int   SYNC_STAGES = 2,
    parameter logic RESET_Q     = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic in_5,
    input  logic in_4,
    input  logic in_7,
    input  logic in_3,
    output logic out_2,
    output logic out_6
);

    // Control word layout: {S, R, D, E}
    logic [3:0] raw_w;
    logic [3:0] ctl_w;
    logic       q_q;
    logic       q_d;
    logic       qbar_q;

    assign raw_w = {in_5, in_4, in_7, in_3};

    if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_cfg
        $error("tics_module: SYNC_STAGES must be in 2..4");
    end

`ifdef TICS_SYNC_EN
    genvar gi;
    for (gi = 0; gi < 4; gi++) begin : g_sync
        logic [SYNC_STAGES-1:0] sync_q;

        // Reset discards anything captured while rst was high.
        always_ff @(posedge clk) begin
            if (rst) begin
                sync_q <= '0;
            end else begin
                sync_q <= {sync_q[SYNC_STAGES-2:0], raw_w[gi]};
            end
        end

        assign ctl_w[gi] = sync_q[SYNC_STAGES-1];
    end
`else
    assign ctl_w = raw_w;
`endif

    always_comb begin
        q_d = q_q;
        if (ctl_w[3] && ctl_w[2]) begin
            q_d = ~q_q;
        end else if (ctl_w[3]) begin
            q_d = 1'b1;
        end else if (ctl_w[2]) begin
            q_d = 1'b0;
        end else if (ctl_w[0]) begin
            q_d = ctl_w[1];
        end
    end

    // qbar has its own flop so both outputs change on the same edge with no comb path.
    always_ff @(posedge clk) begin
        if (rst) begin
            q_q    <= RESET_Q;
            qbar_q <= ~RESET_Q;
        end else begin
            q_q    <= q_d;
            qbar_q <= ~q_d;
        end
    end

    assign out_2 = q_q;
    assign out_6 = qbar_q;

endmodule

// File: tb/tb_tics_module.sv
// Self-checking bench for tics_module: directed literal steps followed by randomized stimulus,
// all compared every cycle against a queue-based behavioural model.
module tb_tics_module;

`ifdef TICS_SYNC_EN
    localparam int DLY = 2;
`else
    localparam int DLY = 0;
`endif
    localparam logic RESET_Q = 1'b0;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] pat = 4'b1111;
    logic       out_2;
    logic       out_6;

    int checks = 0;
    int passes = 0;

    always #5 clk = ~clk;

    tics_module #(.SYNC_STAGES(2), .RESET_Q(RESET_Q)) dut (
        .clk  (clk),
        .rst  (rst),
        .in_5 (pat[3]),
        .in_4 (pat[2]),
        .in_7 (pat[1]),
        .in_3 (pat[0]),
        .out_2(out_2),
        .out_6(out_6)
    );

    // Behavioural model: words reach the decoder DLY edges after being sampled.
    bit         m_q     = 1'b0;
    bit         m_valid = 1'b0;
    logic [3:0] pipe[$];

    function automatic bit decode(bit q, logic [3:0] w);
        if (w[3] && w[2]) return ~q;
        if (w[3])         return 1'b1;
        if (w[2])         return 1'b0;
        if (w[0])         return w[1];
        return q;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            m_q = RESET_Q;
            pipe.delete();
            for (int i = 0; i < DLY; i++) pipe.push_back(4'b0000);
            m_valid = 1'b1;
        end else if (m_valid) begin
            pipe.push_back(pat);
            m_q = decode(m_q, pipe.pop_front());
        end
    end

    task automatic check(input string name, input logic act, input logic exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    endtask

    always @(negedge clk) begin
        if (m_valid) begin
            check("model_q", out_2, m_q);
            check("model_qbar", out_6, ~m_q);
        end
    end

    // Hand-computed expectation: pins both the DUT and the model.
    task automatic lit(input string name, input bit exp_q);
        check(name, out_2, exp_q);
        check({name, "_bar"}, out_6, ~exp_q);
        check({name, "_model"}, m_q, exp_q);
        $display("step %-12s pat=%b out_2=%b out_6=%b expect_q=%b", name, pat, out_2, out_6, exp_q);
    endtask

    task automatic step(input logic [3:0] w, input string name, input bit exp_q);
        pat = w;
        repeat (DLY + 1) @(negedge clk);
        lit(name, exp_q);
    endtask

    initial begin
        repeat (2) begin
            @(negedge clk);
            lit("reset", 1'b0);
        end
        rst = 1'b0;
        pat = 4'b0000;
        @(negedge clk);
        lit("release", 1'b0);

        step(4'b1000, "set", 1'b1);
        step(4'b0100, "clear", 1'b0);
        step(4'b0011, "load1", 1'b1);
        step(4'b0001, "load0", 1'b0);
        step(4'b0010, "d_only", 1'b0);

        pat = 4'b1100;
        repeat (DLY + 1) @(negedge clk);
        lit("toggle1", 1'b1);
        @(negedge clk); lit("toggle2", 1'b0);
        @(negedge clk); lit("toggle3", 1'b1);
        @(negedge clk); lit("toggle4", 1'b0);

        step(4'b1001, "set_vs_e", 1'b1);
        step(4'b0111, "clr_vs_d", 1'b0);

`ifdef TICS_SYNC_EN
        step(4'b0000, "idle", 1'b0);
        pat = 4'b1000;
        repeat (DLY) begin
            @(negedge clk);
            lit("sync_early", 1'b0);
        end
        @(negedge clk);
        lit("sync_rise", 1'b1);

        step(4'b0100, "sync_clr", 1'b0);
        step(4'b0000, "sync_idle", 1'b0);
        pat = 4'b1000;
        @(negedge clk);
        rst = 1'b1;
        pat = 4'b0000;
        @(negedge clk);
        rst = 1'b0;
        repeat (DLY + 2) begin
            @(negedge clk);
            lit("sync_rst", 1'b0);
        end
`endif

        repeat (400) begin
            @(negedge clk);
            rst = ($urandom_range(0, 29) == 0);
            pat = 4'($urandom_range(0, 15));
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/tics_module.md
# tics_module

Single-bit set/clear/load/toggle storage element with complementary outputs, for the MIOC ASIC register test structure (TICS flop). Four control inputs are decoded into a registered state bit `q`. `out_2` presents `q` and `out_6` presents `~q`. An optional input synchronizer lets the control pins be driven asynchronously, for example from a pattern generator.

## Interface
- `SYNC_STAGES`, default 2: depth of the per-input synchronizer when `TICS_SYNC_EN` is defined. Legal range is 2..4.
- `RESET_Q`, default 1'b0: value loaded into `q` by reset.

Ports:
- `clk`  input  1  single clock; all state updates on the rising edge.
- `rst`  input  1  synchronous, active-high reset.
- `in_5`  input  1  S, set request.
- `in_4`  input  1  R, clear request.
- `in_7`  input  1  D, load data.
- `in_3`  input  1  E, load enable.
- `out_2`  output  1  q, stored bit (registered).
- `out_6`  output  1  qbar, complement of q (registered, same edge as `out_2`).

Pattern-word convention: bit3 = `in_5`, bit2 = `in_4`, bit1 = `in_7`, bit0 = `in_3`.

## Operation
- Decode on sampled {S,R,D,E}, evaluated per clock edge in this priority order:
  - `rst`=1: q <= RESET_Q. Synchronizer stages clear to 0.
  - S=1, R=1: q <= ~q (toggle).
  - S=1, R=0: q <= 1.
  - S=0, R=1: q <= 0.
  - S=0, R=0, E=1: q <= D.
  - S=0, R=0, E=0: q holds.
- `out_6` is driven from its own flop, loaded with the complement of the next q. `out_2` ^ `out_6` = 1 at every clock edge after the first reset, with no combinational path from inputs to outputs.
- D is ignored whenever S or R is high.
- Before the first reset, outputs are undefined.

## Timing
- Reset values: `out_2` = RESET_Q (0), `out_6` = ~RESET_Q (1), valid on the edge where `rst` is sampled high.
- Without `TICS_SYNC_EN`:
  - Inputs are sampled directly on the edge.
  - Output reflects the inputs present at edge N immediately after edge N (latency 1).
- With `TICS_SYNC_EN`:
  - Each input passes through SYNC_STAGES flops.
  - Output reflects the inputs present at edge N after edge N+SYNC_STAGES (latency 3 at default).
- Held S=R=1 toggles q every cycle.
- Reset mid-operation: `rst` overrides all inputs on the same edge. Synchronizer contents are discarded, so inputs applied during reset have no effect after deassertion. The first decode after reset uses inputs sampled on the first edge with `rst`=0, delayed by the synchronizer when it is enabled.
- Simultaneous S and R never produce a held or undefined state; they always toggle.

## Configuration
- `TICS_SYNC_EN` defined: a SYNC_STAGES-deep flop synchronizer is inserted on each of the four inputs; latency is SYNC_STAGES+1.
- `TICS_SYNC_EN` undefined: no synchronizer, latency 1, and `SYNC_STAGES` is unused.

## Test plan
- Apply `rst`=1 for 2 cycles with inputs 4'b1111 -> `out_2`=0 and `out_6`=1 throughout, still 0/1 on the cycle after release.
- Hold pattern 4'b1000 (set) after reset -> `out_2`=1, `out_6`=0 after latency. Then 4'b0100 (clear) -> 0/1.
- Apply 4'b0011 (load D=1), then 4'b0001 (load D=0), then 4'b0010 (D=1, E=0) -> q = 1, 0, 0; the D-only pattern holds.
- Hold 4'b1100 for 4 cycles from q=0 -> q sequence 1,0,1,0. `out_6` is always the complement.
- Apply 4'b1001 and 4'b0111 -> q=1 then q=0, showing S/R beats E and D.
- With `TICS_SYNC_EN` defined, drive 4'b1000 at edge N -> `out_2` rises after edge N+2, not earlier. Asserting `rst` at edge N+1 instead -> q stays 0.
